// File: rtl/xcorr_window_accumulator.sv
// Windowed x*r / r*r accumulator producing scaled, saturated numerator/denominator pairs.
// Optional macro XCORR_DEN_FLOOR_EN forces a zero denominator to 1 (den_out also resets to 1).
module xcorr_window_accumulator #(
    parameter int DATA_W    = 16,
    parameter int LOG2_WIN  = 10,
    parameter int OUT_SHIFT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   sample_in,
    input  logic signed [DATA_W-1:0]   ref_in,
    output logic signed [31:0]         num_out,
    output logic signed [31:0]         den_out,
    output logic                       out_valid,
    output logic                       sat_out,
    output logic                       den_zero,
    output logic [LOG2_WIN-1:0]        win_count
);

    localparam int ACC_W = 2*DATA_W + LOG2_WIN;
    localparam int PROD_W = 2*DATA_W;
    // Extra headroom so the 32-bit saturation bounds are always representable.
    localparam int EXT_W = ACC_W + 32;
    localparam logic [LOG2_WIN-1:0] WIN_LAST = '1;
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-31){1'b0}}, {31{1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-31){1'b1}}, {31{1'b0}}};
`ifdef XCORR_DEN_FLOOR_EN
    localparam logic signed [31:0] DEN_RST = 32'sd1;
`else
    localparam logic signed [31:0] DEN_RST = 32'sd0;
`endif

    logic signed [PROD_W-1:0] p_xr;
    logic signed [PROD_W-1:0] p_rr;
    logic                     v1;
    logic signed [ACC_W-1:0]  acc_xr;
    logic signed [ACC_W-1:0]  acc_rr;

    logic signed [EXT_W-1:0]  sum_xr;
    logic signed [EXT_W-1:0]  sum_rr;
    logic signed [EXT_W-1:0]  sh_xr;
    logic signed [EXT_W-1:0]  sh_rr;
    logic signed [31:0]       sat_xr;
    logic signed [31:0]       sat_rr;
    logic signed [31:0]       den_fin;
    logic                     clip_xr;
    logic                     clip_rr;
    logic                     rr_zero;

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        sum_xr  = EXT_W'(acc_xr) + EXT_W'(p_xr);
        sum_rr  = EXT_W'(acc_rr) + EXT_W'(p_rr);
        sh_xr   = sum_xr >>> OUT_SHIFT;
        sh_rr   = sum_rr >>> OUT_SHIFT;
        clip_xr = (sh_xr > SAT_MAX) || (sh_xr < SAT_MIN);
        clip_rr = (sh_rr > SAT_MAX) || (sh_rr < SAT_MIN);
        sat_xr  = sh_xr[31:0];
        sat_rr  = sh_rr[31:0];
        if (sh_xr > SAT_MAX)      sat_xr = 32'sh7FFF_FFFF;
        else if (sh_xr < SAT_MIN) sat_xr = 32'sh8000_0000;
        if (sh_rr > SAT_MAX)      sat_rr = 32'sh7FFF_FFFF;
        else if (sh_rr < SAT_MIN) sat_rr = 32'sh8000_0000;
        rr_zero = (sh_rr == '0);
`ifdef XCORR_DEN_FLOOR_EN
        den_fin = (sat_rr == '0) ? 32'sd1 : sat_rr;
`else
        den_fin = sat_rr;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_xr      <= '0;
            p_rr      <= '0;
            v1        <= 1'b0;
            acc_xr    <= '0;
            acc_rr    <= '0;
            win_count <= '0;
            num_out   <= '0;
            den_out   <= DEN_RST;
            out_valid <= 1'b0;
            sat_out   <= 1'b0;
            den_zero  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (clear) begin
                // Flush drops both the partial window and the product still in stage 1.
                v1        <= 1'b0;
                acc_xr    <= '0;
                acc_rr    <= '0;
                win_count <= '0;
            end else begin
                v1 <= in_valid;
                if (in_valid) begin
                    p_xr <= PROD_W'(sample_in) * PROD_W'(ref_in);
                    p_rr <= PROD_W'(ref_in) * PROD_W'(ref_in);
                end
                if (v1) begin
                    if (win_count == WIN_LAST) begin
                        num_out   <= sat_xr;
                        den_out   <= den_fin;
                        sat_out   <= clip_xr || clip_rr;
                        den_zero  <= rr_zero;
                        out_valid <= 1'b1;
                        acc_xr    <= '0;
                        acc_rr    <= '0;
                        win_count <= '0;
                    end else begin
                        acc_xr    <= acc_xr + ACC_W'(p_xr);
                        acc_rr    <= acc_rr + ACC_W'(p_rr);
                        win_count <= win_count + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_xcorr_window_accumulator.sv
// Directed self-checking bench for xcorr_window_accumulator with a 4-sample window, no output shift.
module tb_xcorr_window_accumulator;

    logic               clk;
    logic               rst;
    logic               clear;
    logic               in_valid;
    logic signed [15:0] sample_in;
    logic signed [15:0] ref_in;
    logic signed [31:0] num_out;
    logic signed [31:0] den_out;
    logic               out_valid;
    logic               sat_out;
    logic               den_zero;
    logic [1:0]         win_count;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int p0;

`ifdef XCORR_DEN_FLOOR_EN
    localparam logic [31:0] DEN_RST  = 32'd1;
    localparam logic [31:0] DEN_ZERO = 32'd1;
`else
    localparam logic [31:0] DEN_RST  = 32'd0;
    localparam logic [31:0] DEN_ZERO = 32'd0;
`endif

    xcorr_window_accumulator #(
        .DATA_W    (16),
        .LOG2_WIN  (2),
        .OUT_SHIFT (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .sample_in (sample_in),
        .ref_in    (ref_in),
        .num_out   (num_out),
        .den_out   (den_out),
        .out_valid (out_valid),
        .sat_out   (sat_out),
        .den_zero  (den_zero),
        .win_count (win_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (out_valid) pulses++;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, $signed(actual), actual,
                     $signed(expected), expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; checks after a step see settled outputs.
    task automatic step(input logic v, input logic signed [15:0] x, input logic signed [15:0] r);
        @(negedge clk);
        clear     = 1'b0;
        in_valid  = v;
        sample_in = x;
        ref_in    = r;
    endtask

    task automatic run_window(input logic signed [15:0] x, input logic signed [15:0] r);
        for (int i = 0; i < 4; i++) step(1'b1, x, r);
    endtask

    // Idle until out_valid is seen (bounded), compare latency, then confirm the pulse drops.
    task automatic wait_pulse(input string tag, input int exp_cycles);
        int n = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 16'sd0, 16'sd0);
            n++;
            if (out_valid) break;
        end
        check({tag, "_latency"}, n, exp_cycles);
        step(1'b0, 16'sd0, 16'sd0);
        check({tag, "_pulse_width"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; sample_in = '0; ref_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(1'b0, 16'sd0, 16'sd0);
        check("rst_num", num_out, 32'd0);
        check("rst_den", den_out, DEN_RST);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sat", {31'd0, sat_out}, 32'd0);
        check("rst_dz", {31'd0, den_zero}, 32'd0);
        check("rst_win", {30'd0, win_count}, 32'd0);

        // Four consecutive 100*100 pairs.
        p0 = pulses;
        run_window(16'sd100, 16'sd100);
        step(1'b0, 16'sd0, 16'sd0);
        check("t1_win_last", {30'd0, win_count}, 32'd3);
        check("t1_early", {31'd0, out_valid}, 32'd0);
        wait_pulse("t1", 1);
        check("t1_num", num_out, 32'd40000);
        check("t1_den", den_out, 32'd40000);
        check("t1_sat", {31'd0, sat_out}, 32'd0);
        check("t1_dz", {31'd0, den_zero}, 32'd0);
        check("t1_win_wrap", {30'd0, win_count}, 32'd0);
        check("t1_pulses", pulses - p0, 32'd1);

        // Full-scale negative pairs: both sums are 2^32 and clip high.
        run_window(-16'sd32768, -16'sd32768);
        wait_pulse("t2", 2);
        check("t2_num", num_out, 32'h7FFF_FFFF);
        check("t2_den", den_out, 32'h7FFF_FFFF);
        check("t2_sat", {31'd0, sat_out}, 32'd1);

        // Opposite signs: numerator clips low, denominator high.
        run_window(-16'sd32768, 16'sd32767);
        wait_pulse("t2b", 2);
        check("t2b_num", num_out, 32'h8000_0000);
        check("t2b_den", den_out, 32'h7FFF_FFFF);
        check("t2b_sat", {31'd0, sat_out}, 32'd1);

        // in_valid every other cycle; win_count observed one edge after each sample.
        p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'sd100, 16'sd100);
            step(1'b0, 16'sd0, 16'sd0);
            check($sformatf("t3_win%0d", i), {30'd0, win_count}, i);
            check($sformatf("t3_idle%0d", i), {31'd0, out_valid}, 32'd0);
        end
        wait_pulse("t3", 1);
        check("t3_num", num_out, 32'd40000);
        check("t3_den", den_out, 32'd40000);
        check("t3_sat", {31'd0, sat_out}, 32'd0);
        check("t3_win_wrap", {30'd0, win_count}, 32'd0);
        check("t3_pulses", pulses - p0, 32'd1);

        // Partial window flushed by clear; the sample offered with clear is discarded.
        p0 = pulses;
        step(1'b1, 16'sd50, 16'sd50);
        step(1'b1, 16'sd50, 16'sd50);
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; sample_in = 16'sd77; ref_in = 16'sd77;
        step(1'b0, 16'sd0, 16'sd0);
        check("t4_win_flush", {30'd0, win_count}, 32'd0);
        check("t4_hold_num", num_out, 32'd40000);
        step(1'b0, 16'sd0, 16'sd0);
        check("t4_win_flush2", {30'd0, win_count}, 32'd0);
        run_window(16'sd10, -16'sd3);
        wait_pulse("t4", 2);
        check("t4_num", num_out, 32'hFFFF_FF88);
        check("t4_den", den_out, 32'd36);
        check("t4_pulses", pulses - p0, 32'd1);

        // Async reset after three samples, away from any clock edge.
        p0 = pulses;
        step(1'b1, 16'sd7, 16'sd7);
        step(1'b1, 16'sd7, 16'sd7);
        step(1'b1, 16'sd7, 16'sd7);
        step(1'b0, 16'sd0, 16'sd0);
        check("t6_win_pre", {30'd0, win_count}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_num", num_out, 32'd0);
        check("t6_rst_den", den_out, DEN_RST);
        check("t6_rst_win", {30'd0, win_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_window(16'sd1, 16'sd1);
        wait_pulse("t6", 2);
        check("t6_num", num_out, 32'd4);
        check("t6_den", den_out, 32'd4);
        check("t6_pulses", pulses - p0, 32'd1);

        // Zero reference: denominator is zero before any floor.
        run_window(16'sd5, 16'sd0);
        wait_pulse("t5", 2);
        check("t5_num", num_out, 32'd0);
        check("t5_den", den_out, DEN_ZERO);
        check("t5_dz", {31'd0, den_zero}, 32'd1);
        check("t5_sat", {31'd0, sat_out}, 32'd0);

        // Back-to-back windows at one sample per clock: nothing lost at the boundary.
        p0 = pulses;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) step(1'b1, 16'sd2, 16'sd2);
            else       step(1'b1, 16'sd3, -16'sd1);
            if (i == 5) begin
                check("t7_w1_valid", {31'd0, out_valid}, 32'd1);
                check("t7_w1_num", num_out, 32'd16);
                check("t7_w1_den", den_out, 32'd16);
                check("t7_w1_dz", {31'd0, den_zero}, 32'd0);
            end
        end
        step(1'b0, 16'sd0, 16'sd0);
        check("t7_w2_early", {31'd0, out_valid}, 32'd0);
        step(1'b0, 16'sd0, 16'sd0);
        check("t7_w2_valid", {31'd0, out_valid}, 32'd1);
        check("t7_w2_num", num_out, 32'hFFFF_FFF4);
        check("t7_w2_den", den_out, 32'd4);
        step(1'b0, 16'sd0, 16'sd0);
        check("t7_pulses", pulses - p0, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
